// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, opcodes,
// handshake constants, data widths and the per-step result record.
package div_pkg;

    localparam int DIV_WIDTH        = 32;
    localparam int DIV_RESULT_WIDTH = 2 * DIV_WIDTH;
    localparam int DIV_CNT_WIDTH    = 6;

    localparam logic [DIV_CNT_WIDTH-1:0] DIV_LAST_STEP = 6'd31;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] rem;
        logic                 q;
    } div_step_t;

    // Lets the EX stage decide whether an ALU opcode must launch the divider.
    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: 33-bit trial subtract of the divisor from the
// shifted partial remainder, yielding the next remainder and one quotient bit.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output div_step_t            step_o
);

    logic [DIV_WIDTH:0] partial;
    logic [DIV_WIDTH:0] diff;

    assign partial = {rem_i, bit_i};
    assign diff    = partial - {1'b0, divisor_i};

    // Bit 32 of the difference is the borrow: set means the divisor did not fit.
    assign step_o.q   = ~diff[DIV_WIDTH];
    assign step_o.rem = diff[DIV_WIDTH] ? partial[DIV_WIDTH-1:0] : diff[DIV_WIDTH-1:0];

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to enable signed division (signed_div_i honoured).
module div
    import div_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        signed_div_i,
    input  logic [DIV_WIDTH-1:0]        opdata1_i,
    input  logic [DIV_WIDTH-1:0]        opdata2_i,
    input  logic                        start_i,
    input  logic                        annul_i,
    output logic [DIV_RESULT_WIDTH-1:0] result_o,
    output logic                        ready_o
);

    logic [1:0]                  state_reg,   state_next;
    logic [DIV_CNT_WIDTH-1:0]    cnt_reg,     cnt_next;
    logic [DIV_WIDTH-1:0]        rem_reg,     rem_next;
    logic [DIV_WIDTH-1:0]        quot_reg,    quot_next;
    logic [DIV_WIDTH-1:0]        divisor_reg, divisor_next;
    logic [DIV_RESULT_WIDTH-1:0] result_reg,  result_next;
    logic                        ready_reg,   ready_next;

    logic                        accept;
    logic [DIV_WIDTH-1:0]        mag1, mag2;
    logic [DIV_WIDTH-1:0]        raw_quot, quot_fin, rem_fin;
    div_step_t                   step;

    assign accept = (state_reg == DIV_FREE) && (start_i == DIV_START) && !annul_i;

    // The dividend shifts out of quot_reg MSB-first while quotient bits shift in.
    div_step u_step (
        .rem_i     (rem_reg),
        .bit_i     (quot_reg[DIV_WIDTH-1]),
        .divisor_i (divisor_reg),
        .step_o    (step)
    );

    assign raw_quot = {quot_reg[DIV_WIDTH-2:0], step.q};

`ifdef DIV_SIGNED_EN
    logic sgn1, sgn2;
    logic neg_quot_reg, neg_rem_reg;

    assign sgn1 = signed_div_i & opdata1_i[DIV_WIDTH-1];
    assign sgn2 = signed_div_i & opdata2_i[DIV_WIDTH-1];
    assign mag1 = sgn1 ? (~opdata1_i + 32'd1) : opdata1_i;
    assign mag2 = sgn2 ? (~opdata2_i + 32'd1) : opdata2_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
        end else if (accept) begin
            neg_quot_reg <= sgn1 ^ sgn2;
            neg_rem_reg  <= sgn1;
        end
    end

    // Magnitude 0x80000000 negates back to itself, giving the two's-complement wrap.
    assign quot_fin = neg_quot_reg ? (~raw_quot + 32'd1) : raw_quot;
    assign rem_fin  = neg_rem_reg  ? (~step.rem + 32'd1) : step.rem;
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div_i;
    assign mag1     = opdata1_i;
    assign mag2     = opdata2_i;
    assign quot_fin = raw_quot;
    assign rem_fin  = step.rem;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rem_next     = rem_reg;
        quot_next    = quot_reg;
        divisor_next = divisor_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;
        case (state_reg)
            DIV_FREE: begin
                result_next = '0;
                ready_next  = DIV_RESULT_NOT_READY;
                if (accept) begin
                    divisor_next = mag2;
                    quot_next    = mag1;
                    rem_next     = '0;
                    cnt_next     = '0;
                    state_next   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                state_next  = DIV_END;
                result_next = '0;
                ready_next  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end else begin
                    rem_next  = step.rem;
                    quot_next = raw_quot;
                    cnt_next  = cnt_reg + 6'd1;
                    if (cnt_reg == DIV_LAST_STEP) begin
                        state_next  = DIV_END;
                        result_next = {rem_fin, quot_fin};
                        ready_next  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DIV_FREE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
            ready_reg   <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_reg     <= rem_next;
            quot_reg    <= quot_next;
            divisor_reg <= divisor_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule
